banked_sram_responder: RTL and testbench

Memory-side responder for the req/rsp SRAM protocol used by the transpose and attention engines. It services single-beat requests into NB interleaved banks, each 2^M words deep. Each bank needs a recovery time between accesses; while the addressed bank is still recovering, the block withholds req_ready. Reads return through a fixed-latency, in-order pipeline, and all contents are zeroed after every reset.

---
 rtl/banked_sram_responder.sv | 92 +++++++++
 tb/tb_banked_sram_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/banked_sram_responder.sv
// banked_sram_responder: NB interleaved SRAM banks with busy gating, in-order fixed-latency reads and post-reset zero fill.
// Define STALL_CNT_EN to add the saturating stall_cnt output.
module banked_sram_responder #(
   parameter int NB       = 8,
   parameter int ADDR_W   = 16,
   parameter int Data_W   = 32,
   parameter int M        = 6,
   parameter int RD_LAT   = 2,
   parameter int BANK_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_v,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] Req_addr,
   input  logic [Data_W-1:0] Req_wData,
   output logic              req_ready,
   output logic [Data_W-1:0] Rsp_rData,
   output logic              rsp_v,
   output logic              init_done,
   output logic              oor_err
`ifdef STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);
   localparam int B_W = $clog2(NB);
   localparam int IW  = B_W + M;
   localparam int CW  = $clog2(BANK_CYC) + 1;
   typedef enum logic {S_INIT, S_RUN} state_t;
   state_t            r_state, w_next;
   logic [M-1:0]      r_cnt;
   logic [CW-1:0]     r_busy [NB];
   logic [Data_W-1:0] r_mem [NB << M];
   logic [RD_LAT-1:0] r_pv;
   logic [Data_W-1:0] r_pd [RD_LAT];
   logic              r_oor;
   logic              w_run, w_acc, w_oor, w_rd;
   logic [B_W-1:0]    w_bank;
   logic [IW-1:0]     w_idx;
   assign w_bank    = Req_addr[B_W-1:0];
   assign w_idx     = Req_addr[IW-1:0];
   assign w_oor     = |Req_addr[ADDR_W-1:IW];
   assign w_acc     = req_v && req_ready;
   assign w_rd      = w_acc && !req_we;
   assign rsp_v     = r_pv[RD_LAT-1];
   assign Rsp_rData = r_pd[RD_LAT-1];
   assign oor_err   = r_oor;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_INIT;
      else        r_state <= w_next;
   always_comb w_next = (r_state == S_INIT && &r_cnt) ? S_RUN : r_state;
   always_comb begin
      w_run     = r_state == S_RUN;
      init_done = w_run;
      req_ready = w_run && r_busy[w_bank] == '0;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                 r_cnt <= '0;
      else if (r_state == S_INIT) r_cnt <= r_cnt + 1'b1;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) for (int b = 0; b < NB; b++) r_busy[b] <= '0;
      else for (int b = 0; b < NB; b++)
         r_busy[b] <= (w_acc && w_bank == B_W'(b)) ? CW'(BANK_CYC - 1)
                    : (r_busy[b] != '0) ? r_busy[b] - 1'b1 : '0;
   // Zero fill clears one row across all banks per cycle; nothing else can be accepted meanwhile.
   always_ff @(posedge clk)
      if (r_state == S_INIT) for (int b = 0; b < NB; b++) r_mem[{r_cnt, B_W'(b)}] <= '0;
      else if (w_acc && req_we && !w_oor) r_mem[w_idx] <= Req_wData;
   // Each data stage only advances with a valid beat, so the last stage holds the previous response.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_pv  <= '0;
         r_oor <= 1'b0;
         for (int k = 0; k < RD_LAT; k++) r_pd[k] <= '0;
      end else begin
         r_oor   <= r_oor | (w_acc && w_oor);
         r_pv[0] <= w_rd;
         if (w_rd) r_pd[0] <= w_oor ? '0 : r_mem[w_idx];
         for (int k = 1; k < RD_LAT; k++) begin
            r_pv[k] <= r_pv[k-1];
            if (r_pv[k-1]) r_pd[k] <= r_pd[k-1];
         end
      end
`ifdef STALL_CNT_EN
   logic [31:0] r_stall;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_stall <= '0;
      else if (w_run && req_v && !req_ready && !(&r_stall)) r_stall <= r_stall + 1'b1;
   assign stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_banked_sram_responder.sv
// tb_banked_sram_responder: directed plus random traffic against a cycle-counting memory model.
module tb_banked_sram_responder;
   localparam int RD_LAT = 2, BANK_CYC = 2;
   logic        clk = 1'b0, rst_n = 1'b0, req_v = 1'b0, req_we = 1'b0;
   logic [15:0] Req_addr = '0;
   logic [31:0] Req_wData = '0;
   logic        req_ready, rsp_v, init_done, oor_err;
   logic [31:0] Rsp_rData;
   int          n_vec = 0, n_err = 0;
`ifdef STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif
   always #5 clk = ~clk;
   banked_sram_responder dut (
      .clk(clk), .rst_n(rst_n), .req_v(req_v), .req_we(req_we), .Req_addr(Req_addr),
      .Req_wData(Req_wData), .req_ready(req_ready), .Rsp_rData(Rsp_rData), .rsp_v(rsp_v),
      .init_done(init_done), .oor_err(oor_err)
`ifdef STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );
   typedef struct {int due; logic [31:0] d;} rsp_t;
   logic [31:0] mem [512];
   int          nxt [8];
   int          n;
   bit          oor;
   logic [31:0] last;
   int unsigned stall;
   rsp_t        q[$];
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h (edge %0d)", tag, obs, exp, n);
      end
   endtask
   task automatic model_reset();
      foreach (mem[i]) mem[i] = '0;
      foreach (nxt[i]) nxt[i] = 0;
      n = 0; oor = 0; last = '0; stall = 0;
      q.delete();
   endtask
   // One clock: drive at the falling edge, check, then advance the model across the rising edge.
   task automatic cyc(input logic rn, input logic v, input logic we, input logic [15:0] a,
                      input logic [31:0] d, output bit acc);
      bit   run, rdy, due, ov;
      rsp_t r;
      @(negedge clk);
      rst_n = rn; req_v = v; req_we = we; Req_addr = a; Req_wData = d;
      if (!rn) model_reset();
      #1;
      run = rn && n >= 64;
      rdy = run && (n + 1 >= nxt[a[2:0]]);
      due = q.size() > 0 && q[0].due == n;
      if (due) begin
         r = q.pop_front();
         last = r.d;
      end
      check("req_ready", req_ready, rdy);
      check("rsp_v", rsp_v, due);
      check("Rsp_rData", Rsp_rData, last);
      check("init_done", init_done, run);
      check("oor_err", oor_err, oor);
`ifdef STALL_CNT_EN
      check("stall_cnt", stall_cnt, stall);
`endif
      acc = rn && v && rdy;
      @(posedge clk);
      if (rn) begin
         n++;
         if (acc) begin
            ov = |a[15:9];
            nxt[a[2:0]] = n + BANK_CYC;
            oor |= ov;
            if (we) begin
               if (!ov) mem[a[8:0]] = d;
            end else begin
               r.due = n + RD_LAT - 1;
               r.d   = ov ? 32'h0 : mem[a[8:0]];
               q.push_back(r);
            end
         end else if (v && run) stall++;
      end
   endtask
   task automatic req(input logic we, input logic [15:0] a, input logic [31:0] d);
      bit acc = 0;
      for (int k = 0; k < 8 && !acc; k++) cyc(1, 1, we, a, d, acc);
      if (!acc) check("accept_timeout", 0, 1);
   endtask
   task automatic idle(input int c, input logic rn);
      bit acc;
      for (int k = 0; k < c; k++) cyc(rn, 0, 0, '0, '0, acc);
   endtask
   initial begin
      bit acc;
      model_reset();
      idle(3, 0);
      for (int i = 0; i < 64; i++) cyc(1, 1'($urandom), 1'($urandom), 16'($urandom), $urandom, acc);
      req(0, 16'h0005, '0);
      req(1, 16'h0005, 32'h3F800000);
      req(0, 16'h0005, '0);
      idle(3, 1);
      req(0, 16'h0000, '0);
      req(0, 16'h0008, '0);
      idle(2, 1);
      req(0, 16'h0000, '0);
      req(0, 16'h0001, '0);
      req(1, 16'h0000, 32'h12345678);
      idle(2, 1);
      req(1, 16'h0200, 32'hDEADBEEF);
      req(0, 16'h0200, '0);
      req(0, 16'h0000, '0);
      idle(3, 1);
      req(1, 16'h0002, 32'hCAFEF00D);
      req(0, 16'h0001, '0);
      req(0, 16'h0002, '0);
      req(0, 16'h0003, '0);
      idle(2, 0);
      idle(66, 1);
      req(0, 16'h0001, '0);
      req(0, 16'h0002, '0);
      req(0, 16'h0003, '0);
      idle(3, 1);
      for (int i = 0; i < 2000; i++)
         cyc(($urandom % 400) != 0, ($urandom % 10) < 7, 1'($urandom),
             ($urandom % 40 == 0) ? 16'($urandom) : 16'($urandom % 512), $urandom, acc);
      idle(4, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
